// File: rtl/mc_core.sv
// Multi-cycle RV32I-subset core: one FSM state per cycle, with waits only in the
// FETCH and MEM handshakes. Stops in TRAP on any undecodable instruction.
module mc_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ILL
    } op_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic              rf_we;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    op_e        op;
    logic       use_rd, use_rs1, use_rs2, bad_reg, taken;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    // ir_q is stable from DECODE until the next fetch, so decode stays combinational.
    always_comb begin
        op      = OP_ILL;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: op = OP_ADD;
                    10'b0100000_000: op = OP_SUB;
                    10'b0000000_111: op = OP_AND;
                    10'b0000000_110: op = OP_OR;
                    10'b0000000_100: op = OP_XOR;
                    10'b0000000_010: op = OP_SLT;
                    default:         op = OP_ILL;
                endcase
            end
            7'b0010011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                if (f3 == 3'b000) op = OP_ADDI;
            end
            7'b0000011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                if (f3 == 3'b010) op = OP_LW;
            end
            7'b0100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (f3 == 3'b010) op = OP_SW;
            end
            7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (f3 == 3'b000) op = OP_BEQ;
                else if (f3 == 3'b001) op = OP_BNE;
            end
            default: op = OP_ILL;
        endcase
    end

    // Only the fields an instruction actually uses as register indices are range-checked.
    assign bad_reg = (use_rd  && ({1'b0, rd}  >= 6'(NREGS))) ||
                     (use_rs1 && ({1'b0, rs1} >= 6'(NREGS))) ||
                     (use_rs2 && ({1'b0, rs2} >= 6'(NREGS)));

    assign taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        rf_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_ILL || bad_reg) begin
                    state_d = S_TRAP;
                end else begin
                    a_d     = regs_q[rs1[AW-1:0]];
                    b_d     = regs_q[rs2[AW-1:0]];
                    imm_d   = (op == OP_SW) ? imm_s :
                              (op == OP_BEQ || op == OP_BNE) ? imm_b : imm_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  res_d = a_q + b_q;
                    OP_SUB:  res_d = a_q - b_q;
                    OP_AND:  res_d = a_q & b_q;
                    OP_OR:   res_d = a_q | b_q;
                    OP_XOR:  res_d = a_q ^ b_q;
                    OP_SLT:  res_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                    OP_ADDI, OP_LW, OP_SW: res_d = a_q + imm_q;
                    default: res_d = res_q;
                endcase
                if (op == OP_BEQ || op == OP_BNE) begin
                    pc_d    = taken ? pc_q + imm_q : pc_q + XLEN'(4);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (op == OP_SW) begin
                        pc_d    = pc_q + XLEN'(4);
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_q + XLEN'(4);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // x0 is never written, so its entry stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            regs_q[rd[AW-1:0]] <= res_q;
        end
    end

    // Requests are gated by rst so an in-flight handshake drops the moment reset asserts.
    assign imem_req   = rst && (state_q == S_FETCH);
    assign dmem_req   = rst && (state_q == S_MEM);
    assign dmem_we    = dmem_req && (op == OP_SW);
    assign imem_addr  = pc_q;
    assign dmem_addr  = res_q;
    assign dmem_wdata = b_q;
    assign halted     = (state_q == S_TRAP);
    assign instret    = cnt_q;

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: directed scenarios plus a random program run
// against an instruction-level reference model.
module tb_mc_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [1024];

    // Main DUT: default parameters.
    logic        rst, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, instret;
    assign imem_rdata = prog[imem_addr[11:2]];

    mc_core dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halted(halted), .instret(instret)
    );

    // Second DUT: 64-bit datapath, 16 registers, 4-bit counter.
    logic        rst2, imem_ready2, dmem_ready2;
    logic        imem_req2, dmem_req2, dmem_we2, halted2;
    logic [63:0] imem_addr2, dmem_addr2, dmem_wdata2, dmem_rdata2;
    logic [31:0] imem_rdata2;
    logic [3:0]  instret2;
    assign imem_rdata2 = prog[imem_addr2[11:2]];

    mc_core #(.XLEN(64), .NREGS(16), .RESET_PC(64'h400), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ready(dmem_ready2), .dmem_rdata(dmem_rdata2), .halted(halted2), .instret(instret2)
    );

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] off, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ILL  = 32'h0000_007F;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) prog[i] = NOP;
        do_reset();
        imem_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (instret !== 32'd2) begin errors++; $display("FAIL pre_reset_instret got %0d exp 2", instret); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || halted !== 1'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got ireq=%b dreq=%b we=%b halt=%b cnt=%0d exp 0 0 0 0 0",
                     imem_req, dmem_req, dmem_we, halted, instret);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_fetch got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_alu_mem();
        prog[0] = enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
        prog[2] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3] = enc_s(12'd8, 5'd3, 5'd0);
        prog[4] = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
        prog[5] = enc_s(12'd12, 5'd4, 5'd0);
        prog[6] = ILL;
        do_reset();
        imem_ready = 1'b1;
        repeat (12) step();
        checks++;
        if (instret !== 32'd3 || imem_addr !== 32'd12 || imem_req !== 1'b1) begin
            errors++; $display("FAIL alu_12cyc got cnt=%0d addr=%h exp 3 0000000c", instret, imem_addr);
        end
        repeat (3) step();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'd8 || dmem_wdata !== 32'd2 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL sw_hold c=%0d got req=%b we=%b addr=%h data=%h exp 1 1 8 2", c, dmem_req, dmem_we, dmem_addr, dmem_wdata);
            end
            if (c == 3) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || instret !== 32'd4 || imem_addr !== 32'd16) begin
            errors++; $display("FAIL sw_done got req=%b cnt=%0d addr=%h exp 0 4 10", dmem_req, instret, imem_addr);
        end
        repeat (3) step();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'd8) begin
                errors++; $display("FAIL lw_hold c=%0d got req=%b we=%b addr=%h exp 1 0 8", c, dmem_req, dmem_we, dmem_addr);
            end
            if (c == 3) begin dmem_ready = 1'b1; dmem_rdata = 32'd2; end
            step();
        end
        dmem_ready = 1'b0; dmem_rdata = '0;
        step();
        checks++;
        if (instret !== 32'd5 || imem_addr !== 32'd20) begin
            errors++; $display("FAIL lw_done got cnt=%0d addr=%h exp 5 14", instret, imem_addr);
        end
        repeat (3) step();
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'd12 || dmem_wdata !== 32'd2) begin
            errors++; $display("FAIL lw_value got addr=%h data=%h exp c 2", dmem_addr, dmem_wdata);
        end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        checks++;
        if (instret !== 32'd6) begin errors++; $display("FAIL sw2_retire got %0d exp 6", instret); end
    endtask

    task automatic test_branch_trap();
        for (int i = 0; i < 4; i++) prog[i] = NOP;
        prog[4] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
        do_reset();
        imem_ready = 1'b1;
        repeat (16) step();
        checks++;
        if (imem_addr !== 32'h10) begin errors++; $display("FAIL beq_pc got %h exp 10", imem_addr); end
        repeat (3) step();
        checks++;
        if (imem_addr !== 32'h08 || instret !== 32'd5) begin
            errors++; $display("FAIL beq_taken got addr=%h cnt=%0d exp 08 5", imem_addr, instret);
        end
        prog[4] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b001);
        prog[5] = ILL;
        do_reset();
        imem_ready = 1'b1;
        repeat (19) step();
        checks++;
        if (imem_addr !== 32'h14 || instret !== 32'd5) begin
            errors++; $display("FAIL bne_not_taken got addr=%h cnt=%0d exp 14 5", imem_addr, instret);
        end
        step();
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL trap_early got halted=%b exp 0", halted); end
        step();
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || instret !== 32'd5) begin
            errors++; $display("FAIL trap_enter got halt=%b ireq=%b dreq=%b cnt=%0d exp 1 0 0 5", halted, imem_req, dmem_req, instret);
        end
        dmem_ready = 1'b1;
        repeat (5) step();
        dmem_ready = 1'b0;
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || imem_addr !== 32'h14 || instret !== 32'd5) begin
            errors++; $display("FAIL trap_frozen got halt=%b ireq=%b addr=%h cnt=%0d exp 1 0 14 5", halted, imem_req, imem_addr, instret);
        end
    endtask

    task automatic test_reset_mid();
        prog[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011);
        prog[1] = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
        prog[2] = enc_s(12'd4, 5'd5, 5'd0);
        do_reset();
        imem_ready = 1'b1;
        repeat (7) step();
        checks++;
        if (dmem_req !== 1'b1 || instret !== 32'd1) begin
            errors++; $display("FAIL abort_setup got req=%b cnt=%0d exp 1 1", dmem_req, instret);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || instret !== 32'd0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL abort_async got dreq=%b cnt=%0d ireq=%b exp 0 0 0", dmem_req, instret, imem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL abort_restart got req=%b addr=%h exp 1 0", imem_req, imem_addr);
        end
        repeat (7) step();
        dmem_ready = 1'b1; dmem_rdata = 32'h99;
        step();
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (4) step();
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h99 || instret !== 32'd2) begin
            errors++; $display("FAIL abort_rerun got req=%b we=%b data=%h cnt=%0d exp 1 1 99 2", dmem_req, dmem_we, dmem_wdata, instret);
        end
    endtask

    task automatic test_param64();
        bit seen = 1'b0;
        prog[256] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[257] = enc_s(12'd0, 5'd1, 5'd0);
        for (int i = 258; i < 273; i++) prog[i] = NOP;
        prog[273] = enc_i(12'd0, 5'd16, 3'b000, 5'd1, 7'b0010011);
        @(negedge clk);
        rst2 = 1'b1;
        for (int c = 0; c < 300 && !halted2; c++) begin
            step();
            if (dmem_req2 === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (dmem_wdata2 !== 64'hFFFF_FFFF_FFFF_FFFF || dmem_we2 !== 1'b1 || dmem_addr2 !== 64'd0) begin
                    errors++; $display("FAIL x64_addi got data=%h we=%b addr=%h exp ffffffffffffffff 1 0", dmem_wdata2, dmem_we2, dmem_addr2);
                end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL x64_store got none exp one store"); end
        checks++;
        if (halted2 !== 1'b1 || instret2 !== 4'd1 || imem_addr2 !== 64'h444 || imem_req2 !== 1'b0) begin
            errors++; $display("FAIL cnt_wrap_nregs got halt=%b cnt=%0d addr=%h exp 1 1 444", halted2, instret2, imem_addr2);
        end
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [11:0] imm = 12'($urandom);
        int          r   = int'($urandom_range(0, 9));
        case (r)
            0, 1, 2, 3: begin
                case ($urandom_range(0, 5))
                    0: return enc_r(7'h00, rs2, rs1, 3'b000, rd);
                    1: return enc_r(7'h20, rs2, rs1, 3'b000, rd);
                    2: return enc_r(7'h00, rs2, rs1, 3'b111, rd);
                    3: return enc_r(7'h00, rs2, rs1, 3'b110, rd);
                    4: return enc_r(7'h00, rs2, rs1, 3'b100, rd);
                    default: return enc_r(7'h00, rs2, rs1, 3'b010, rd);
                endcase
            end
            4, 5: return enc_i(imm, 5'd0, 3'b000, rd, 7'b0010011);
            6:    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
            7:    return enc_s(imm, rs2, rs1);
            8:    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
            default: return enc_b(13'(4 * $urandom_range(1, 3)), rs2, rs1, 3'($urandom_range(0, 1)));
        endcase
    endfunction

    // Instruction-level reference: each fetched word is executed on an architectural
    // register array and a sparse memory, then the bus traffic and timing are compared.
    task automatic test_random(int n);
        logic [31:0] mr [32];
        logic [31:0] dm [logic [31:0]];
        logic [31:0] pc, cnt, inst, a, b, addr, res, npc, imm_i, imm_s, imm_b;
        int kind;
        bit wr;
        for (int i = 0; i < 32; i++) mr[i] = '0;
        pc = '0; cnt = '0;
        do_reset();
        for (int k = 0; k < n; k++) begin
            imem_ready = 1'b0; dmem_ready = 1'($urandom_range(0, 1));
            inst = gen_inst();
            prog[pc[11:2]] = inst;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc) begin
                errors++; $display("FAIL rnd_fetch k=%0d got req=%b addr=%h exp 1 %h", k, imem_req, imem_addr, pc);
            end
            repeat ($urandom_range(0, 2)) step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc) begin
                errors++; $display("FAIL rnd_fetch_hold k=%0d got req=%b addr=%h exp 1 %h", k, imem_req, imem_addr, pc);
            end
            imem_ready = 1'b1;
            step();
            imem_ready = 1'($urandom_range(0, 1));

            a = mr[inst[19:15]]; b = mr[inst[24:20]];
            imm_i = {{20{inst[31]}}, inst[31:20]};
            imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            npc = pc + 32'd4; wr = 1'b1; kind = 0; addr = '0; res = '0;
            case (inst[6:0])
                7'b0110011: case ({inst[30], inst[14:12]})
                    4'b0000: res = a + b;
                    4'b1000: res = a - b;
                    4'b0111: res = a & b;
                    4'b0110: res = a | b;
                    4'b0100: res = a ^ b;
                    default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                endcase
                7'b0010011: res = a + imm_i;
                7'b0000011: begin kind = 1; addr = a + imm_i; end
                7'b0100011: begin kind = 2; addr = a + imm_s; wr = 1'b0; end
                default: begin
                    kind = 3; wr = 1'b0;
                    if ((inst[12] == 1'b0) ? (a == b) : (a != b)) npc = pc + imm_b;
                end
            endcase

            step();
            checks++;
            if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL rnd_idle k=%0d got ireq=%b dreq=%b exp 0 0", k, imem_req, dmem_req);
            end
            dmem_ready = 1'b0;
            step();
            if (kind == 1 || kind == 2) begin
                repeat ($urandom_range(0, 2)) step();
                checks++;
                if (dmem_req !== 1'b1 || dmem_addr !== addr || dmem_we !== (kind == 2) ||
                    (kind == 2 && dmem_wdata !== b)) begin
                    errors++;
                    $display("FAIL rnd_mem k=%0d got req=%b we=%b addr=%h data=%h exp 1 %0d %h %h",
                             k, dmem_req, dmem_we, dmem_addr, dmem_wdata, kind == 2, addr, b);
                end
                if (kind == 1) begin
                    if (!dm.exists(addr)) dm[addr] = $urandom;
                    res = dm[addr];
                    dmem_rdata = res;
                end else begin
                    dm[addr] = b;
                end
                dmem_ready = 1'b1;
                step();
                dmem_ready = 1'b0;
                if (kind == 1) step();
            end else if (kind == 0) begin
                step();
            end
            if (wr && inst[11:7] != 5'd0) mr[inst[11:7]] = res;
            cnt = cnt + 32'd1;
            pc = npc;
            checks++;
            if (instret !== cnt) begin
                errors++; $display("FAIL rnd_instret k=%0d got %0d exp %0d", k, instret, cnt);
            end
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== pc) begin
            errors++; $display("FAIL rnd_final got req=%b addr=%h exp 1 %h", imem_req, imem_addr, pc);
        end
    endtask

    initial begin
        rst2 = 1'b0; imem_ready2 = 1'b1; dmem_ready2 = 1'b1; dmem_rdata2 = '0;
        test_reset();
        test_alu_mem();
        test_branch_trap();
        test_reset_mid();
        test_param64();
        test_random(80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
